serial_word_deserializer: RTL and testbench
===========================================

// Module: serial_word_deserializer
//
// PURPOSE
//  Receive end of the serial shift link: collects a bit-serial stream, MSB- or
//  LSB-first, into WIDTH-bit parallel words. Presents each word through a
//  one-entry valid/ready holding register and flags words it has to drop.
//  Sits between the serial line (shift-register transmitter output) and the
//  parallel datapath.
//
// PARAMETERS
//  WIDTH   8   data bits per word (>=2)
//
// PORTS
//  clk        in   1              rising-edge clock (single clock domain)
//  reset      in   1              asynchronous reset, active-high
//  clear      in   1              synchronous abort/flush, active-high
//  bit_in     in   1              serial data bit
//  bit_valid  in   1              bit_in sampled on this edge when high
//  msb_first  in   1              1: first bit -> out_data[WIDTH-1]; 0: first bit -> out_data[0]
//  out_data   out  WIDTH          assembled word, stable while out_valid
//  out_valid  out  1              holding register full
//  out_ready  in   1              consumer accepts word (out_valid & out_ready at edge)
//  overrun    out  1              sticky: a completed word was dropped
//  bit_count  out  $clog2(WIDTH+2) bits received in current frame
//
// BEHAVIOUR
//  - Reset (async): shift reg, bit_count, out_data, out_valid, overrun = 0.
//  - Priority: reset > clear > normal. clear: same values as reset, on the edge.
//  - Frame length F = WIDTH (WIDTH+1 with PARITY_CHECK_EN). Gaps allowed:
//    bit_valid=0 edges change nothing in the shifter/counter.
//  - Direction latched when bit_count==0 && bit_valid; mid-frame changes of
//    msb_first ignored until the next frame.
//  - Shift: MSB-first sreg <= {sreg[W-2:0],bit_in}; LSB-first sreg <= {bit_in,sreg[W-1:1]}.
//  - bit_count increments per accepted bit; on last bit (count==F-1) wraps to 0.
//  - Completion edge (last data bit accepted): word incl. that bit is written to
//    out_data and out_valid=1 on the SAME edge (zero extra latency).
//  - Handshake: out_valid&&out_ready at edge -> out_valid<=0 unless a completion
//    occurs on that edge, in which case new word loads and out_valid stays 1.
//  - Completion with out_valid=1 && out_ready=0: new word dropped, out_data
//    unchanged, overrun<=1 (sticky until reset/clear). Shifter still restarts.
//  - out_ready while out_valid=0: no effect.
//  - Reset or clear mid-frame: partial bits discarded; next bit starts a frame.
//
// CONFIGURATION
//  PARITY_CHECK_EN defined: frame is WIDTH+1 bits; final bit is even parity over
//   the data bits, not stored in out_data. Extra port parity_err (out, 1): loads
//   with out_data on completion (1 = parity mismatch), held while out_valid,
//   cleared on reset/clear; dropped words do not update it. Completion edge is the
//   parity-bit edge.
//  Not defined: frame is WIDTH bits, no parity_err port, no parity logic.
//
// TESTING
//  1. msb_first=1, bits 1,0,1,0,0,1,0,1 -> out_data=8'hA5, out_valid=1 at 8th bit edge.
//  2. msb_first=0, bits 1,0,1,1,0,1,0,0 with 2-cycle gaps -> out_data=8'h2D.
//  3. out_ready=0, send 8'h11 then 8'h22 -> out_data=8'h11, overrun=1; out_ready=1
//     -> out_valid drops next edge, overrun stays 1 until clear.
//  4. out_valid=1, out_ready=1 on completion edge of 8'h5A -> out_valid stays 1,
//     out_data=8'h5A, overrun=0.
//  5. 3 bits sent, reset pulse (async, mid-cycle) -> all outputs 0 immediately;
//     next 8 bits 8'hC3 -> out_data=8'hC3. Repeat with clear -> same result.
//  6. PARITY_CHECK_EN: 8'hA5 + parity 0 -> parity_err=0; 8'hA5 + parity 1 ->
//     parity_err=1, out_data=8'hA5.

Source files
------------

// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer
//   Receive end of the serial shift link. Collects a bit-serial stream,
//   MSB-first or LSB-first, into WIDTH-bit words. Each finished word is
//   presented through a one-entry valid/ready holding register. A word that
//   finishes while the holding register is still full is dropped, and the
//   sticky overrun flag is set.
//
//   Optional feature macro: PARITY_CHECK_EN
//     When defined, each frame carries WIDTH data bits followed by one even
//     parity bit. The parity bit is not stored in out_data. A parity_err
//     port is added; it is updated together with out_data.
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   clear            synchronous flush; returns outputs to their reset values
//   bit_in/bit_valid serial bit, sampled on edges where bit_valid is high
//   msb_first        1: first bit lands in out_data[WIDTH-1]; 0: first bit lands in out_data[0]
//   out_data/out_valid/out_ready  holding register and its handshake
//   overrun          sticky flag: a completed word was dropped
//   bit_count        number of bits received so far in the current frame
//   parity_err       (PARITY_CHECK_EN only) parity mismatch on the held word
module serial_word_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  input  logic                          msb_first,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overrun,
`ifdef PARITY_CHECK_EN
  output logic                          parity_err,
`endif
  output logic [$clog2(WIDTH+2)-1:0]    bit_count
);

  localparam int CW = $clog2(WIDTH+2);
`ifdef PARITY_CHECK_EN
  localparam int F = WIDTH + 1;
`else
  localparam int F = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_IDX  = CW'(F - 1);
  localparam logic [CW-1:0] WIDTH_CNT = CW'(WIDTH);

  logic [WIDTH-1:0] sreg, shifted, word;
  logic             dir_q, dir, last, data_bit;

  // The first bit of a frame uses the live msb_first input.
  // Every later bit uses the direction latched on that first bit.
  assign dir     = (bit_count == '0) ? msb_first : dir_q;
  assign shifted = dir ? {sreg[WIDTH-2:0], bit_in} : {bit_in, sreg[WIDTH-1:1]};
  assign last    = bit_valid && (bit_count == LAST_IDX);

`ifdef PARITY_CHECK_EN
  logic perr_new;
  // The trailing parity bit is never shifted in.
  // The word is already complete in sreg when the parity bit arrives.
  assign data_bit = (bit_count < WIDTH_CNT);
  assign word     = sreg;
  assign perr_new = (^sreg) ^ bit_in;
`else
  assign data_bit = 1'b1;
  assign word     = shifted;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg      <= '0;
      dir_q     <= 1'b0;
      bit_count <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
    end else if (clear) begin
      sreg      <= '0;
      dir_q     <= 1'b0;
      bit_count <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (bit_valid) begin
        if (bit_count == '0) dir_q <= msb_first;
        if (data_bit)        sreg  <= shifted;
        bit_count <= last ? '0 : bit_count + 1'b1;
      end
      if (last) begin
        // A completion takes priority over a plain pop.
        // If the consumer pops on the same edge, the new word replaces the old one.
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end else begin
          out_data  <= word;
          out_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
          parity_err <= perr_new;
`endif
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_deserializer.sv
module tb_serial_word_deserializer;
`ifdef PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0, reset = 1'b1, clear = 1'b0;
  logic       bit_in = 1'b0, bit_valid = 1'b0, msb_first = 1'b1, out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, overrun;
  logic [3:0] bit_count;
`ifdef PARITY_CHECK_EN
  logic       parity_err;
`endif
  int n_cmp = 0, n_err = 0;

  serial_word_deserializer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .clear(clear), .bit_in(bit_in),
    .bit_valid(bit_valid), .msb_first(msb_first), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun),
`ifdef PARITY_CHECK_EN
    .parity_err(parity_err),
`endif
    .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One accepted bit; returns 1 time unit after the sampling edge.
  task automatic send_bit(input logic b, input logic rdy);
    @(negedge clk);
    bit_in = b; bit_valid = 1'b1; out_ready = rdy;
    @(posedge clk); #1;
    bit_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends w in the given direction, with `gap` idle edges between bits.
  // flip: toggles msb_first after the first bit; the toggle must be ignored.
  // rdy_last: holds out_ready high on the completion edge.
  task automatic send_word(input logic [7:0] w, input logic msb, input int gap,
                           input bit flip, input bit rdy_last, input bit badpar);
    logic b;
    msb_first = msb;
    for (int i = 0; i < 8; i++) begin
      b = msb ? w[7-i] : w[i];
      send_bit(b, (i == 7 && !PAR) ? rdy_last : 1'b0);
      if (flip && i == 0) msb_first = ~msb;
      if (gap > 0 && i < 7) idle(gap);
    end
    if (PAR) send_bit((^w) ^ badpar, rdy_last);
    msb_first = msb;
  endtask

  task automatic consume;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'h0);
    chk("rst_ovr",   32'(overrun),   32'd0);
    chk("rst_cnt",   32'(bit_count), 32'd0);
    reset = 1'b0;

    // 1: MSB-first A5; also check the bit counter partway through a frame
    msb_first = 1'b1;
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    chk("t1_cnt3",  32'(bit_count), 32'd3);
    chk("t1_nvld",  32'(out_valid), 32'd0);
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    if (PAR) send_bit(1'b0, 1'b0);
    chk("t1_data",  32'(out_data),  32'hA5);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_cnt0",  32'(bit_count), 32'd0);
    consume;
    chk("t1_pop",   32'(out_valid), 32'd0);

    // 2: LSB-first 2D with gaps; msb_first toggles mid-frame and must be ignored
    send_word(8'h2D, 1'b0, 2, 1'b1, 1'b0, 1'b0);
    chk("t2_data",  32'(out_data),  32'h2D);
    chk("t2_valid", 32'(out_valid), 32'd1);
    consume;

    // 3: overrun
    send_word(8'h11, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("t3_ovr0",  32'(overrun),   32'd0);
    send_word(8'h22, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("t3_data",  32'(out_data),  32'h11);
    chk("t3_ovr1",  32'(overrun),   32'd1);
    consume;
    chk("t3_pop",   32'(out_valid), 32'd0);
    chk("t3_sticky",32'(overrun),   32'd1);
    @(negedge clk); clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    chk("t3_clr",   32'(overrun),   32'd0);

    // 4: a pop and a completion on the same edge
    send_word(8'h33, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    send_word(8'h5A, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_data",  32'(out_data),  32'h5A);
    chk("t4_ovr",   32'(overrun),   32'd0);

    // 5a: async reset in the middle of a frame (out_valid is still 1 here)
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("t5_rvld",  32'(out_valid), 32'd0);
    chk("t5_rdata", 32'(out_data),  32'h0);
    chk("t5_rcnt",  32'(bit_count), 32'd0);
    reset = 1'b0;
    send_word(8'hC3, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("t5_data_r",32'(out_data),  32'hC3);

    // 5b: clear in the middle of a frame
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    @(negedge clk); clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    chk("t5_cvld",  32'(out_valid), 32'd0);
    chk("t5_ccnt",  32'(bit_count), 32'd0);
    chk("t5_cdata", 32'(out_data),  32'h0);
    send_word(8'hC3, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("t5_data_c",32'(out_data),  32'hC3);
    chk("t5_vld_c", 32'(out_valid), 32'd1);

`ifdef PARITY_CHECK_EN
    // 6: parity check
    consume;
    send_word(8'hA5, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("t6_pe0",   32'(parity_err), 32'd0);
    consume;
    send_word(8'hA5, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    chk("t6_pe1",   32'(parity_err), 32'd1);
    chk("t6_data",  32'(out_data),   32'hA5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
